// File: rtl/cla_subtractor_16bit_pipe.sv
// Two-stage pipelined 16-bit CLA subtractor: diff = a - b - bin, valid/ready on both sides.
// Optional zero/slt flag outputs enabled by defining CLA_SUB_FLAGS_EN.
module cla_subtractor_16bit_pipe #(
    parameter int WIDTH = 16,
    parameter int SPLIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
`ifdef CLA_SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             slt
`endif
);

    localparam int HW  = WIDTH - SPLIT;
    localparam int NLO = SPLIT / 4;
    localparam int NHI = HW / 4;

    generate
        if (WIDTH != 16) begin : g_bad_width
            $error("cla_subtractor_16bit_pipe: WIDTH must be 16");
        end
        if ((SPLIT % 4) != 0 || SPLIT < 4 || SPLIT > 12) begin : g_bad_split
            $error("cla_subtractor_16bit_pipe: SPLIT must be 4, 8 or 12");
        end
    endgenerate

    // 4-bit lookahead group: returns {carry_out, sum[3:0]}
    function automatic logic [4:0] cla4(
        input logic [3:0] p,
        input logic [3:0] g,
        input logic       c0
    );
        logic [4:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | ((&p) & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    logic             s1_valid;
    logic [SPLIT-1:0] s1_lo;
    logic             s1_c;
    logic [HW-1:0]    s1_a_hi;
    logic [HW-1:0]    s1_nb_hi;
    logic             s1_a15;
    logic             s1_b15;
    logic             s2_valid;

    logic in_fire;
    logic s2_load;

    assign s2_load   = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || s2_load;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;

    logic [SPLIT-1:0] lo_p;
    logic [SPLIT-1:0] lo_g;
    logic [SPLIT-1:0] lo_sum;
    logic [NLO:0]     lo_c;

    // Subtraction as a + ~b + ~bin over the low groups
    always_comb begin
        lo_p    = a[SPLIT-1:0] ^ ~b[SPLIT-1:0];
        lo_g    = a[SPLIT-1:0] & ~b[SPLIT-1:0];
        lo_c    = '0;
        lo_sum  = '0;
        lo_c[0] = ~bin;
        for (int i = 0; i < NLO; i++) begin
            {lo_c[i+1], lo_sum[4*i +: 4]} =
                cla4(lo_p[4*i +: 4], lo_g[4*i +: 4], lo_c[i]);
        end
    end

    logic [HW-1:0]    hi_p;
    logic [HW-1:0]    hi_g;
    logic [HW-1:0]    hi_sum;
    logic [NHI:0]     hi_c;
    logic [WIDTH-1:0] d_n;
    logic             bout_n;
    logic             ovf_n;

    always_comb begin
        hi_p    = s1_a_hi ^ s1_nb_hi;
        hi_g    = s1_a_hi & s1_nb_hi;
        hi_c    = '0;
        hi_sum  = '0;
        hi_c[0] = s1_c;
        for (int i = 0; i < NHI; i++) begin
            {hi_c[i+1], hi_sum[4*i +: 4]} =
                cla4(hi_p[4*i +: 4], hi_g[4*i +: 4], hi_c[i]);
        end
        d_n    = {hi_sum, s1_lo};
        bout_n = ~hi_c[NHI];
        ovf_n  = (s1_a15 != s1_b15) && (d_n[WIDTH-1] != s1_a15);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_lo    <= '0;
            s1_c     <= 1'b0;
            s1_a_hi  <= '0;
            s1_nb_hi <= '0;
            s1_a15   <= 1'b0;
            s1_b15   <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_lo    <= lo_sum;
            s1_c     <= lo_c[NLO];
            s1_a_hi  <= a[WIDTH-1:SPLIT];
            s1_nb_hi <= ~b[WIDTH-1:SPLIT];
            s1_a15   <= a[WIDTH-1];
            s1_b15   <= b[WIDTH-1];
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Result registers only change on a load, so they hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
            ovf      <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            diff     <= d_n;
            bout     <= bout_n;
            ovf      <= ovf_n;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

`ifdef CLA_SUB_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            zero <= 1'b0;
            slt  <= 1'b0;
        end else if (s2_load) begin
            zero <= (d_n == '0);
            slt  <= d_n[WIDTH-1] ^ ovf_n;
        end
    end
`endif

endmodule

// File: tb/tb_cla_subtractor_16bit_pipe.sv
// Scoreboard bench for cla_subtractor_16bit_pipe with an arithmetic reference model.
// Flag outputs are checked too when CLA_SUB_FLAGS_EN is defined.
module tb_cla_subtractor_16bit_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
`ifdef CLA_SUB_FLAGS_EN
    logic        zero;
    logic        slt;
`endif

    always #5 clk = ~clk;

    cla_subtractor_16bit_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
`ifdef CLA_SUB_FLAGS_EN
        ,
        .zero      (zero),
        .slt       (slt)
`endif
    );

    typedef struct {
        logic [15:0] d;
        logic        bo;
        logic        ov;
        logic        z;
        logic        s;
    } exp_t;

    exp_t q[$];
    int   nchk   = 0;
    int   nerr   = 0;
    int   acc    = 0;
    int   stalls = 0;

    function automatic exp_t model(input logic [15:0] ma,
                                   input logic [15:0] mb,
                                   input logic        mbin);
        exp_t e;
        int   u;
        int   s;
        u    = int'(ma) - int'(mb) - int'(mbin);
        s    = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        e.d  = u[15:0];
        e.bo = (u < 0);
        e.ov = (s < -32768) || (s > 32767);
        e.z  = (e.d == 16'h0000);
        e.s  = (s < 0);
        return e;
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Input-side monitor: a beat seen with in_valid && in_ready here is taken at the next edge
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            q.push_back(model(a, b, bin));
            acc++;
        end
    end

    logic        stall_prev = 1'b0;
    logic [15:0] hold_d;
    logic        hold_bo;
    logic        hold_ov;
    exp_t        e;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_diff", 32'(diff), 32'(hold_d));
                chk("hold_bout", 32'(bout), 32'(hold_bo));
                chk("hold_ovf", 32'(ovf), 32'(hold_ov));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("diff", 32'(diff), 32'(e.d));
                    chk("bout", 32'(bout), 32'(e.bo));
                    chk("ovf", 32'(ovf), 32'(e.ov));
`ifdef CLA_SUB_FLAGS_EN
                    chk("zero", 32'(zero), 32'(e.z));
                    chk("slt", 32'(slt), 32'(e.s));
`endif
                end
            end
            stall_prev = out_valid && !out_ready;
            hold_d     = diff;
            hold_bo    = bout;
            hold_ov    = ovf;
        end
    end

    task automatic send(input logic [15:0] sa, input logic [15:0] sb,
                        input logic sbin);
        int w;
        w        = 0;
        in_valid = 1'b1;
        a        = sa;
        b        = sb;
        bin      = sbin;
        @(negedge clk);
        while (!in_ready) begin
            w++;
            if (w > 100) begin
                chk("send_timeout", 32'(w), 32'd0);
                break;
            end
            @(negedge clk);
        end
        stalls += w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        bin      = 1'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic bp_done;
    int   acc0;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        send(16'h1234, 16'h0234, 1'b0);
        @(negedge clk);
        chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
        chk("first_diff", 32'(diff), 32'h1000);
        drain();

        send(16'h0000, 16'h0001, 1'b0);
        send(16'h0000, 16'h0000, 1'b1);
        send(16'h8000, 16'h0001, 1'b0);
        send(16'h7FFF, 16'hFFFF, 1'b0);
        send(16'h0005, 16'h0005, 1'b0);
        send(16'hFFFE, 16'h0001, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b1);
        drain();

        acc0      = acc;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send(16'($urandom), 16'($urandom), 1'($urandom));
            end
            begin
                repeat (4) @(negedge clk);
                chk("bp_accepted", 32'(acc - acc0), 32'd2);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        stalls = 0;
        for (int i = 0; i < 1000; i++)
            send(16'($urandom), 16'($urandom), 1'($urandom));
        chk("tp_stalls", 32'(stalls), 32'd0);
        drain();

        bp_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    send(16'($urandom), 16'($urandom), 1'($urandom));
                end
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        send(16'h4321, 16'h1111, 1'b0);
        send(16'h0001, 16'h0002, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_diff", 32'(diff), 32'd0);
        chk("mid_rst_bout", 32'(bout), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        send(16'hABCD, 16'h1234, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
